// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
// Bundles everything the fetch sequencer exchanges with its neighbours: instruction
// ROM, branch LUT, control decoder and run control.
//   master : the fetch sequencer (drives pc/stage/opcode/instr/done/stack_err/counters)
//   slave  : ROM/decoder/run-control side (drives start/instr_in/target/jump/call/ret)
interface fetch_sequencer_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int OPW     = 5
);
  logic               start;
  logic [INSTR_W-1:0] instr_in;
  logic [PC_W-1:0]    target;
  logic               jump;
  logic               call;
  logic               ret;
  logic [PC_W-1:0]    pc;
  logic [1:0]         stage;
  logic [OPW-1:0]     opcode;
  logic [INSTR_W-1:0] instr;
  logic               done;
  logic               stack_err;
  logic [31:0]        cycle_cnt;
  logic [31:0]        instr_cnt;

  modport master (
    input  start, instr_in, target, jump, call, ret,
    output pc, stage, opcode, instr, done, stack_err, cycle_cnt, instr_cnt
  );

  modport slave (
    output start, instr_in, target, jump, call, ret,
    input  pc, stage, opcode, instr, done, stack_err, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Owns the PC, the 4-phase stage counter and the instruction register, and keeps a
// hardware return-address stack for call/ret. Provides start/done run control.
// Ports:
//   clk   : clock, all state updates on posedge
//   rst_n : synchronous active-low reset
//   bus   : fetch_sequencer_if.master (ROM, branch target, decoder flags, status)
// Optional feature: define PERF_COUNT_EN to build the cycle/instruction counters;
// without it cycle_cnt and instr_cnt read as 0.
//
// state  | meaning
// S_IDLE | after reset, waiting for start
// S_RUN  | executing, stage counter advancing
// S_HALT | run ended (PROG_END retired or stack error), waiting for start
module fetch_sequencer #(
  parameter int PC_W     = 10,
  parameter int INSTR_W  = 9,
  parameter int OPW      = 5,
  parameter int DEPTH    = 4,
  parameter int PROG_END = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_sequencer_if.master bus
);
  localparam int SPW  = $clog2(DEPTH + 1);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [1:0]         stage_q, stage_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [SPW-1:0]     sp_q, sp_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [PC_W-1:0]    stack_q [DEPTH];
  logic               push_en;
  logic [IDXW-1:0]    push_idx;
  logic [PC_W-1:0]    push_val;
`ifdef PERF_COUNT_EN
  logic [31:0]        cyc_q, cyc_d, icnt_q, icnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    stage_d  = stage_q;
    ir_d     = ir_q;
    sp_d     = sp_q;
    done_d   = done_q;
    err_d    = err_q;
    push_en  = 1'b0;
    push_idx = IDXW'(sp_q);
    push_val = pc_q + 1'b1;
`ifdef PERF_COUNT_EN
    cyc_d    = cyc_q;
    icnt_d   = icnt_q;
`endif
    case (state_q)
      S_RUN: begin
        stage_d = stage_q + 2'd1;
`ifdef PERF_COUNT_EN
        cyc_d = cyc_q + 32'd1;
`endif
        if (stage_q == 2'd0) ir_d = bus.instr_in;
        if (stage_q == 2'd3) begin
`ifdef PERF_COUNT_EN
          icnt_d = icnt_q + 32'd1;
`endif
          // Stack errors leave pc and stack untouched and end the run.
          if (bus.ret) begin
            if (sp_q == '0) begin
              state_d = S_HALT;
              done_d  = 1'b1;
              err_d   = 1'b1;
            end else begin
              pc_d = stack_q[IDXW'(sp_q - 1'b1)];
              sp_d = sp_q - 1'b1;
            end
          end else if (bus.call) begin
            if (sp_q == SPW'(DEPTH)) begin
              state_d = S_HALT;
              done_d  = 1'b1;
              err_d   = 1'b1;
            end else begin
              push_en = 1'b1;
              pc_d    = bus.target;
              sp_d    = sp_q + 1'b1;
            end
          end else if (bus.jump) begin
            pc_d = bus.target;
          end else if (pc_q == PC_W'(PROG_END)) begin
            state_d = S_HALT;
            done_d  = 1'b1;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      default: begin
        stage_d = 2'd0;
        if (bus.start) begin
          state_d = S_RUN;
          pc_d    = '0;
          sp_d    = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
`ifdef PERF_COUNT_EN
          cyc_d   = '0;
          icnt_d  = '0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      stage_q <= 2'd0;
      ir_q    <= '0;
      sp_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PERF_COUNT_EN
      cyc_q   <= '0;
      icnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stage_q <= stage_d;
      ir_q    <= ir_d;
      sp_q    <= sp_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef PERF_COUNT_EN
      cyc_q   <= cyc_d;
      icnt_q  <= icnt_d;
`endif
    end
  end

  // Stack storage needs no reset; sp bounds which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && push_en) stack_q[push_idx] <= push_val;
  end

  // Stage 00 shows the ROM word directly so the decoder has it the cycle it latches.
  assign bus.instr     = (stage_q == 2'd0) ? bus.instr_in : ir_q;
  assign bus.opcode    = bus.instr[INSTR_W-1 -: OPW];
  assign bus.pc        = pc_q;
  assign bus.stage     = stage_q;
  assign bus.done      = done_q;
  assign bus.stack_err = err_q;
`ifdef PERF_COUNT_EN
  assign bus.cycle_cnt = cyc_q;
  assign bus.instr_cnt = icnt_q;
`else
  assign bus.cycle_cnt = 32'd0;
  assign bus.instr_cnt = 32'd0;
`endif
endmodule
